// File: rtl/seq_detect_mealy.sv
// Mealy serial-pattern detector with a runtime-loadable pattern of 1..PAT_W bits.
// Define SEQ_DETECT_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detect_mealy #(
    parameter int               PAT_W       = 3,
    parameter logic [PAT_W-1:0] DEF_PATTERN = 3'b110,
    parameter int               CNT_W       = 8,
    localparam int              LEN_W       = $clog2(PAT_W+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             clr_count,
    output logic             detect,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {EMPTY, FILLING, ARMED} phase_t;

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [PAT_W-2:0] hist_q;
    logic [LEN_W-1:0] fill_q;

    phase_t           phase;
    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] mask;
    logic             hit;

    always_comb begin
        win  = {hist_q, in_bit};
        mask = '0;
        for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len_q));
        // ARMED once the history holds len-1 bits; with len=1 that is already true at fill=0
        if (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q}) phase = ARMED;
        else if (fill_q == '0)                                    phase = EMPTY;
        else                                                      phase = FILLING;
        hit = (((win ^ pat_q) & mask) == '0);
    end

    assign detect = in_valid & ~cfg_load & (phase == ARMED) & hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(PAT_W);
            hist_q <= '0;
            fill_q <= '0;
        end else if (cfg_load) begin
            pat_q  <= cfg_pattern;
            len_q  <= (cfg_len != '0 && cfg_len <= LEN_W'(PAT_W)) ? cfg_len : LEN_W'(PAT_W);
            fill_q <= '0;
        end else if (in_valid) begin
            hist_q <= win[PAT_W-2:0];
            // non-overlap: the completing bit must not seed the next match
            if (detect && !overlap)              fill_q <= '0;
            else if (fill_q != LEN_W'(PAT_W-1)) fill_q <= fill_q + 1'b1;
        end
    end

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         cnt_q <= '0;
        else if (clr_count)                cnt_q <= CNT_W'(detect);
        else if (detect && cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
    end

    assign match_count = cnt_q;
`else
    logic unused_clr;
    assign unused_clr  = clr_count;
    assign match_count = '0;
`endif

endmodule

// File: doc/seq_detect_mealy.md
# seq_detect_mealy

Parametrised Mealy serial-pattern detector, the successor to our fixed 3-bit "110" detector. It matches a runtime-loadable pattern of 1..PAT_W bits on a qualified serial bit stream. It asserts `detect` combinationally in the same cycle as the completing bit. Overlapping and non-overlapping match modes are supported, plus an optional saturating match counter. It sits between a serial deserialiser front end and the control/status logic.

## Interface
- `PAT_W`, default 3: maximum pattern length in bits (≥2).
- `DEF_PATTERN`, default `3'b110`: pattern loaded at reset; width PAT_W.
- `CNT_W`, default 8: match counter width.
- `LEN_W`, derived as `$clog2(PAT_W+1)`: length field width. Not overridable.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: `in_bit` is valid this cycle.
- `in_bit`, input, 1: serial data bit.
- `overlap`, input, 1: 1 = overlapping matches, 0 = non-overlapping. Sampled every cycle.
- `cfg_load`, input, 1: load `cfg_pattern`/`cfg_len` at the next edge.
- `cfg_pattern`, input, PAT_W: new pattern. Bit `len-1` is the first-received bit; bit 0 is the last.
- `cfg_len`, input, LEN_W: new pattern length.
- `clr_count`, input, 1: synchronous clear of `match_count`.
- `detect`, output, 1: Mealy match indication (combinational).
- `match_count`, output, CNT_W: registered count of matches, saturating.

## Operation
- Registered state:
  - `pat_reg` (PAT_W), `len_reg` (LEN_W).
  - `hist` (PAT_W-1): the last valid bits, newest at bit 0.
  - `fill` (0..PAT_W-1): the number of valid history bits. This is the FSM state: EMPTY at 0, FILLING at 1..len-2, ARMED at ≥len-1.
  - `match_count`.
- Window: `win = {hist, in_bit}`. Compare the low `len_reg` bits of `win` and `pat_reg`.
- `detect = in_valid & ~cfg_load & (fill >= len_reg-1) & (win[len-1:0] == pat_reg[len-1:0])`.
- Valid bit with no `cfg_load`:
  - `hist` shifts left with `in_bit`.
  - `fill` increments, saturating at PAT_W-1.
- Non-overlap mode (`overlap=0`) with `detect=1`: `fill` is set to 0, so the completing bit cannot start a new match. `hist` still shifts.
- Overlap mode with `detect=1`: `fill` follows the normal rule, so shared suffix/prefix bits can complete further matches.
- `in_valid=0`: `hist` and `fill` hold; `detect=0`.
- `cfg_load=1`:
  - `pat_reg` ← `cfg_pattern`.
  - `len_reg` ← `cfg_len` if 1 ≤ `cfg_len` ≤ PAT_W, else PAT_W.
  - `fill` ← 0.
  - The same-cycle `in_bit` is discarded and `detect` is 0.
- `len_reg=1`: ARMED from EMPTY; every valid bit equal to `pat_reg[0]` detects.
- Counter:
  - `detect` → +1, saturating at 2^CNT_W-1.
  - `clr_count` → 0.
  - `clr_count` and `detect` in the same cycle → 1.

## Timing
- Reset values:
  - `pat_reg=DEF_PATTERN`, `len_reg=PAT_W`, `hist=0`, `fill=0`, `match_count=0`.
  - `detect` is 0 while `reset` is high, because `fill=0` and PAT_W≥2.
- `detect` has zero latency: it is combinational from state, `in_bit`, `in_valid` and `cfg_load`. Consumers sample it at the clock edge.
- `match_count` reflects a match one cycle after `detect`.
- New config takes effect for bits presented in the cycle after `cfg_load`. The first match is possible `len` valid bits later.
- A reset mid-sequence discards partial history immediately. The next match needs a full `len` valid bits after deassertion.
- A change to `overlap` applies from the current cycle's `detect` update onward.

## Configuration
- Macro: `SEQ_DETECT_COUNT_EN`.
- Defined: the counter is implemented as described above.
- Undefined:
  - No counter registers are built.
  - `match_count` is tied to 0.
  - `clr_count` is ignored.
  - `detect` behaviour is unchanged.

## Test plan
- Reset defaults: PAT_W=3, overlap=1, stream 1,1,0,1,1,0 → `detect` high on bits 3 and 6 only; `match_count`=2 after the last edge.
- Overlap vs non-overlap: load 4'b1010 (len 4, PAT_W=4) and send 1,0,1,0,1,0.
  - overlap=1: `detect` on bits 4 and 6.
  - overlap=0: `detect` on bit 4 only.
- Gaps and runtime reload:
  - Stream 1,1,0 with `in_valid` low between bits → `detect` on the third valid bit only.
  - `cfg_load` with pattern 2'b01, len 2 while `in_valid=1` → no detect that cycle; the following 0,1 → `detect` on the 1.
- Length clamp: `cfg_len=0` and `cfg_len=PAT_W+1` both load `len=PAT_W`. With `cfg_len=1` and pattern bit 1 → every valid 1 detects.
- Counter: CNT_W=2, five matches → `match_count` saturates at 3. `clr_count` coincident with `detect` → 1. With the macro undefined → `match_count` stays 0.
- Reset mid-operation: after bits 1,1, assert `reset` asynchronously; then send 0 → no detect. Then 1,1,0 → `detect` on the final 0.
